redmule_mx_dec_arbiter: RTL and testbench

//  Shares one redmule_mx_decoder between NREQ MX operand streams (e.g. X and W streamers).
//  - Block-granular round-robin arbitration: one MX block is one DATA_W value word plus one 8-bit shared exponent.
//  - Captures the granted block, issues it to the decoder, and routes the NUM_ELEMS FP16 results back to the owner.
//  - Only after all NUM_ELEMS results does it re-arbitrate.
//  - Sits between the streamer MX ports and the decoder, ahead of the FP16 operand buffers.

---
 rtl/redmule_mx_dec_arbiter.sv | 164 ++++++++++++++++
 tb/tb_redmule_mx_dec_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_mx_dec_arbiter.sv
// Block-granular round-robin arbiter that shares one MX decoder between NREQ operand streams.
// A granted block is latched, issued to the decoder, and its NUM_ELEMS FP16 results are routed back to the owner.
module redmule_mx_dec_arbiter #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NREQ      = 2,
  parameter int unsigned NUM_ELEMS = DATA_W / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ*DATA_W-1:0]    req_val_data_i,
  input  logic [NREQ*8-1:0]         req_exp_data_i,
  output logic                      mx_val_valid_o,
  input  logic                      mx_val_ready_i,
  output logic [DATA_W-1:0]         mx_val_data_o,
  output logic                      mx_exp_valid_o,
  input  logic                      mx_exp_ready_i,
  output logic [7:0]                mx_exp_data_o,
  input  logic                      fp16_valid_i,
  output logic                      fp16_ready_o,
  input  logic [BITW-1:0]           fp16_data_i,
  output logic [NREQ-1:0]           out_valid_o,
  input  logic [NREQ-1:0]           out_ready_i,
  output logic [BITW-1:0]           out_data_o,
  output logic                      out_last_o,
  output logic [$clog2(NREQ)-1:0]   owner_o,
  output logic                      busy_o
);

  localparam int unsigned OW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(NUM_ELEMS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [OW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     elem_cnt_q, elem_cnt_d;
  logic              val_sent_q, val_sent_d;
  logic              exp_sent_q, exp_sent_d;
  logic [DATA_W-1:0] val_data_q, val_data_d;
  logic [7:0]        exp_data_q, exp_data_d;

  logic [DATA_W-1:0] req_val_arr [NREQ];
  logic [7:0]        req_exp_arr [NREQ];

  logic              grant_vld;
  logic [OW-1:0]     grant_idx;
  logic [OW:0]       cand;
  logic [OW:0]       next_ptr;
  logic              val_hs, exp_hs, fp16_hs;
  logic              val_done, exp_done;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_val_arr[gi] = req_val_data_i[gi*DATA_W +: DATA_W];
      assign req_exp_arr[gi] = req_exp_data_i[gi*8 +: 8];
      assign req_ready_o[gi] = (state_q == IDLE) && grant_vld && (grant_idx == OW'(gi));
      assign out_valid_o[gi] = (state_q == DRAIN) && fp16_valid_i && (owner_q == OW'(gi));
    end
  endgenerate

  // Scan downward so the candidate closest to rr_ptr (offset 0) is written last and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr_q} + (OW+1)'(i);
      if (cand >= (OW+1)'(NREQ)) cand = cand - (OW+1)'(NREQ);
      if (req_valid_i[cand[OW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[OW-1:0];
      end
    end
    next_ptr = {1'b0, grant_idx} + (OW+1)'(1);
    if (next_ptr >= (OW+1)'(NREQ)) next_ptr = next_ptr - (OW+1)'(NREQ);
  end

  assign mx_val_valid_o = (state_q == ISSUE) && !val_sent_q;
  assign mx_exp_valid_o = (state_q == ISSUE) && !exp_sent_q;
  assign mx_val_data_o  = val_data_q;
  assign mx_exp_data_o  = exp_data_q;
  assign fp16_ready_o   = (state_q == DRAIN) && out_ready_i[owner_q];
  assign out_data_o     = fp16_data_i;
  assign out_last_o     = (state_q == DRAIN) && fp16_valid_i && (elem_cnt_q == CW'(NUM_ELEMS - 1));
  assign owner_o        = owner_q;
  assign busy_o         = (state_q != IDLE);

  assign val_hs   = mx_val_valid_o && mx_val_ready_i;
  assign exp_hs   = mx_exp_valid_o && mx_exp_ready_i;
  assign fp16_hs  = fp16_valid_i && fp16_ready_o;
  assign val_done = val_sent_q || val_hs;
  assign exp_done = exp_sent_q || exp_hs;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    elem_cnt_d = elem_cnt_q;
    val_sent_d = val_sent_q;
    exp_sent_d = exp_sent_q;
    val_data_d = val_data_q;
    exp_data_d = exp_data_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          val_data_d = req_val_arr[grant_idx];
          exp_data_d = req_exp_arr[grant_idx];
          owner_d    = grant_idx;
          rr_ptr_d   = next_ptr[OW-1:0];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // The two channels complete independently; leave only once both words are out.
        if (val_done && exp_done) begin
          val_sent_d = 1'b0;
          exp_sent_d = 1'b0;
          elem_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          val_sent_d = val_done;
          exp_sent_d = exp_done;
        end
      end
      DRAIN: begin
        if (fp16_hs) begin
          elem_cnt_d = elem_cnt_q + CW'(1);
          if (elem_cnt_q == CW'(NUM_ELEMS - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      elem_cnt_q <= '0;
      val_sent_q <= 1'b0;
      exp_sent_q <= 1'b0;
      val_data_q <= '0;
      exp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      elem_cnt_q <= elem_cnt_d;
      val_sent_q <= val_sent_d;
      exp_sent_q <= exp_sent_d;
      val_data_q <= val_data_d;
      exp_data_q <= exp_data_d;
    end
  end

endmodule

// File: tb/tb_redmule_mx_dec_arbiter.sv
// Self-checking bench: behavioural MX decoder stub, grant table, scoreboard of routed FP16 results.
module tb_redmule_mx_dec_arbiter;

  localparam int DATA_W = 256;
  localparam int BITW   = 16;
  localparam int NREQ   = 2;
  localparam int NE     = DATA_W / 8;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*DATA_W-1:0] req_val_data_i;
  logic [NREQ*8-1:0]      req_exp_data_i;
  logic                   mx_val_valid_o, mx_val_ready_i;
  logic [DATA_W-1:0]      mx_val_data_o;
  logic                   mx_exp_valid_o, mx_exp_ready_i;
  logic [7:0]             mx_exp_data_o;
  logic                   fp16_valid_i, fp16_ready_o;
  logic [BITW-1:0]        fp16_data_i;
  logic [NREQ-1:0]        out_valid_o, out_ready_i;
  logic [BITW-1:0]        out_data_o;
  logic                   out_last_o;
  logic [0:0]             owner_o;
  logic                   busy_o;

  always #5 clk = ~clk;

  redmule_mx_dec_arbiter #(.DATA_W(DATA_W), .BITW(BITW), .NREQ(NREQ)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_val_data_i(req_val_data_i), .req_exp_data_i(req_exp_data_i),
    .mx_val_valid_o(mx_val_valid_o), .mx_val_ready_i(mx_val_ready_i), .mx_val_data_o(mx_val_data_o),
    .mx_exp_valid_o(mx_exp_valid_o), .mx_exp_ready_i(mx_exp_ready_i), .mx_exp_data_o(mx_exp_data_o),
    .fp16_valid_i(fp16_valid_i), .fp16_ready_o(fp16_ready_o), .fp16_data_i(fp16_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_last_o(out_last_o), .owner_o(owner_o), .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // E4M3 normal value scaled by 2^(s-127), re-encoded as FP16.
  function automatic logic [15:0] dec(input logic [7:0] v, input logic [7:0] s);
    int fe;
    fe = int'(v[6:3]) - 7 + int'(s) - 127 + 15;
    return {v[7], fe[4:0], v[2:0], 7'b0};
  endfunction

  function automatic logic [255:0] mk_word(input int s);
    logic [255:0] w;
    logic [7:0]   b;
    w = '0;
    for (int i = 0; i < NE; i++) begin
      b[7]   = ((i + s) % 2) == 1;
      b[6:3] = 4'(3 + ((i + s) % 9));
      b[2:0] = 3'(i * 3 + s);
      w[i*8 +: 8] = b;
    end
    return w;
  endfunction

  function automatic logic [7:0] exp_for(input int k, input int r);
    return 8'(124 + (k + r) % 7);
  endfunction

  // Decoder stub
  logic       val_rdy_en, exp_rdy_en, force_fp16;
  logic       have_val, have_exp, emit;
  logic [255:0] dv;
  logic [7:0] de;
  int         di, val_hs_cnt, exp_hs_cnt;

  assign mx_val_ready_i = val_rdy_en && !have_val;
  assign mx_exp_ready_i = exp_rdy_en && !have_exp;
  assign fp16_valid_i   = emit || force_fp16;
  assign fp16_data_i    = emit ? dec(dv[di*8 +: 8], de) : 16'hDEAD;

  always @(posedge clk) begin
    if (rst_i) begin
      have_val <= 1'b0; have_exp <= 1'b0; emit <= 1'b0; di <= 0;
      dv <= '0; de <= '0; val_hs_cnt <= 0; exp_hs_cnt <= 0;
    end else begin
      if (mx_val_valid_o && mx_val_ready_i) begin
        have_val <= 1'b1; dv <= mx_val_data_o; val_hs_cnt <= val_hs_cnt + 1;
      end
      if (mx_exp_valid_o && mx_exp_ready_i) begin
        have_exp <= 1'b1; de <= mx_exp_data_o; exp_hs_cnt <= exp_hs_cnt + 1;
      end
      if (!emit && have_val && have_exp) begin
        emit <= 1'b1; di <= 0;
      end else if (emit && fp16_ready_o) begin
        if (di == NE - 1) begin
          emit <= 1'b0; have_val <= 1'b0; have_exp <= 1'b0; di <= 0;
        end else begin
          di <= di + 1;
        end
      end
    end
  end

  // Scoreboard: push on block acceptance, pop on each routed result.
  typedef struct {
    int          owner;
    logic [15:0] data;
    logic        last;
  } sb_t;
  sb_t sb_q[$];
  int  res_cnt = 0;

  always @(negedge clk) begin : mon
    sb_t t;
    int  g;
    if (!rst_i) begin
      if ((req_valid_i & req_ready_o) != '0) begin
        g = req_ready_o[1] ? 1 : 0;
        for (int e = 0; e < NE; e++) begin
          t.owner = g;
          t.data  = dec(req_val_data_i[g*DATA_W + e*8 +: 8], req_exp_data_i[g*8 +: 8]);
          t.last  = (e == NE - 1);
          sb_q.push_back(t);
        end
      end
      if ((out_valid_o & out_ready_i) != '0) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: result %0h with nothing expected", out_data_o);
        end else begin
          t = sb_q.pop_front();
          chk("out_owner", out_valid_o, 256'(2'b01 << t.owner));
          chk("out_data", out_data_o, t.data);
          chk("out_last", out_last_o, t.last);
          res_cnt++;
        end
      end
      if (out_valid_o != '0)
        chk("fp16_ready_mirror", fp16_ready_o, |(out_valid_o & out_ready_i));
    end
  end

  task automatic set_data(input int k);
    logic [255:0] w0;
    logic [7:0]   e0;
    w0 = (k == 0) ? {32{8'h38}} : mk_word(2 * k);
    e0 = (k == 0) ? 8'h7F : exp_for(k, 0);
    req_val_data_i = {mk_word(2 * k + 1), w0};
    req_exp_data_i = {exp_for(k, 1), e0};
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (req_ready_o != '0) got = 1'b1;
    end
  endtask

  // mode 0: plain, 1: exponent ready delayed, 2: owner ready toggling.
  task automatic run_block(input logic [1:0] mask, input int g, input int k, input int mode);
    logic [255:0] wg;
    logic [7:0]   eg;
    int           vb, eb;
    bit           got;
    @(posedge clk); #1;
    set_data(k);
    wg = req_val_data_i[g*DATA_W +: DATA_W];
    eg = req_exp_data_i[g*8 +: 8];
    vb = val_hs_cnt;
    eb = exp_hs_cnt;
    if (mode == 1) exp_rdy_en = 1'b0;
    req_valid_i = mask;
    wait_grant(got);
    if (!got) begin
      fail_now("grant_timeout");
      req_valid_i = '0;
      exp_rdy_en  = 1'b1;
      return;
    end
    chk("grant", req_ready_o, 256'(2'b01 << g));
    @(posedge clk); #1;
    req_valid_i = '0;
    @(negedge clk);
    chk("owner", owner_o, 256'(g));
    chk("grant_one_cycle", req_ready_o, 0);
    chk("issue_val_valid", mx_val_valid_o, 1);
    chk("issue_exp_valid", mx_exp_valid_o, 1);
    chk("issue_val_data", mx_val_data_o, wg);
    chk("issue_exp_data", mx_exp_data_o, eg);
    if (mode == 1) begin
      repeat (3) @(posedge clk);
      #1 exp_rdy_en = 1'b1;
      @(negedge clk);
      chk("val_sent_hold", mx_val_valid_o, 0);
      chk("exp_pending", mx_exp_valid_o, 1);
      @(negedge clk);
      chk("exp_sent", mx_exp_valid_o, 0);
      chk("val_not_resent", mx_val_valid_o, 0);
      chk("drain_entered", fp16_ready_o, 1);
    end
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(posedge clk); #1;
      if (mode == 2) out_ready_i[g] = ~out_ready_i[g];
      @(negedge clk);
      if (!busy_o) got = 1'b1;
    end
    out_ready_i = '1;
    if (!got) fail_now("done_timeout");
    chk("sb_drained", sb_q.size(), 0);
    if (mode == 1) begin
      chk("val_hs_count", val_hs_cnt - vb, 1);
      chk("exp_hs_count", exp_hs_cnt - eb, 1);
    end
  endtask

  typedef struct {
    logic [1:0] mask;
    int         grant;
  } vec_t;
  vec_t tbl[10];

  initial begin
    bit got;
    int base;
    tbl[0] = '{2'b01, 0}; tbl[1] = '{2'b01, 0}; tbl[2] = '{2'b10, 1};
    tbl[3] = '{2'b11, 0}; tbl[4] = '{2'b11, 1}; tbl[5] = '{2'b11, 0};
    tbl[6] = '{2'b11, 1}; tbl[7] = '{2'b10, 1}; tbl[8] = '{2'b11, 0};
    tbl[9] = '{2'b10, 1};

    rst_i = 1'b1; req_valid_i = '0; out_ready_i = '1;
    req_val_data_i = '0; req_exp_data_i = '0;
    val_rdy_en = 1'b1; exp_rdy_en = 1'b1; force_fp16 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_val_valid", mx_val_valid_o, 0);
    chk("rst_exp_valid", mx_exp_valid_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_fp16_ready", fp16_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_owner", owner_o, 0);
    chk("rst_val_data", mx_val_data_o, 0);
    chk("rst_exp_data", mx_exp_data_o, 0);

    for (int i = 0; i < 10; i++) run_block(tbl[i].mask, tbl[i].grant, i, 0);

    // Continuous requests from both: strict rotation, blocks never interleave.
    @(posedge clk); #1;
    set_data(20);
    req_valid_i = 2'b11;
    for (int n = 0; n < 4; n++) begin
      wait_grant(got);
      if (!got) begin
        fail_now("cont_grant_timeout");
        break;
      end
      chk("cont_grant", req_ready_o, 256'(2'b01 << (n % 2)));
      @(posedge clk); #1;
      if (n == 3) req_valid_i = '0;
      @(negedge clk);
      chk("cont_owner", owner_o, 256'(n % 2));
    end
    req_valid_i = '0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (!busy_o) got = 1'b1;
    end
    if (!got) fail_now("cont_done_timeout");
    chk("cont_sb_drained", sb_q.size(), 0);

    run_block(2'b01, 0, 21, 1);
    run_block(2'b10, 1, 22, 2);

    // Reset in the middle of a drain.
    @(posedge clk); #1;
    set_data(30);
    req_valid_i = 2'b01;
    wait_grant(got);
    if (!got) fail_now("rst_grant_timeout");
    chk("rst_blk_grant", req_ready_o, 1);
    @(posedge clk); #1;
    req_valid_i = '0;
    base = res_cnt;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk); #1;
      if (res_cnt - base >= 10) got = 1'b1;
    end
    if (!got) fail_now("rst_elem_timeout");
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_val_valid", mx_val_valid_o, 0);
    chk("midrst_exp_valid", mx_exp_valid_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_fp16_ready", fp16_ready_o, 0);
    chk("midrst_owner", owner_o, 0);
    run_block(2'b11, 0, 31, 0);
    run_block(2'b10, 1, 32, 0);

    // Stray decoder output while idle is never routed.
    @(posedge clk); #1;
    force_fp16 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("idle_fp16_ready", fp16_ready_o, 0);
      chk("idle_out_valid", out_valid_o, 0);
    end
    @(posedge clk); #1;
    force_fp16 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
